// File: rtl/trace_commit_sched_pkg.sv
// Shared types for the commit trace scheduler.
// Optional feature macro: TRACE_INST_EN adds the instruction word to each record.
package trace_pkg;

    // One retired-instruction record as held in the trace FIFO
    typedef struct packed {
        logic [63:0] pc;
        logic        skip;
        logic        ebreak;
`ifdef TRACE_INST_EN
        logic [31:0] inst;
`endif
    } trace_rec_t;

    // Scheduler phases: normal commit, draining up to ebreak, halted
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/trace_commit_sched_fifo.sv
// Synchronous FIFO of trace records with full/empty/count status.
// Callers must not push when full or pop when empty.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  trace_rec_t               wdata_i,
    input  logic                     pop_i,
    output trace_rec_t               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    trace_rec_t          mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;

    // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage; contents are don't-care while unoccupied, so no reset
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/trace_commit_sched.sv
// Commit-to-trace scheduler: buffers retired records for a slow trace sink,
// stops accepting after ebreak, halts once the ebreak record is consumed,
// and flags a sticky watchdog after WDOG_CYC cycles without a commit.
// Optional feature macro: TRACE_INST_EN carries cm_inst through to trc_inst.
module trace_commit_sched
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned WDOG_CYC = 65536
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cm_valid,
    output logic        cm_ready,
    input  logic [63:0] cm_pc,
    input  logic        cm_skip,
    input  logic        cm_ebreak,
    input  logic [63:0] cm_a0,
    input  logic [31:0] cm_inst,
    output logic        trc_valid,
    input  logic        trc_ready,
    output logic [63:0] trc_pc,
    output logic        trc_skip,
    output logic [31:0] trc_inst,
    output logic        halt,
    output logic [63:0] halt_code,
    output logic        wdog_trip
);

    localparam int unsigned WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

    sched_state_e        state_q;
    logic                halt_q;
    logic [63:0]         halt_code_q;
    logic [63:0]         pend_code_q;
    logic [WW-1:0]       wdog_cnt_q, wdog_cnt_d;
    logic                wdog_trip_q, wdog_trip_d;

    trace_rec_t          wdata;
    trace_rec_t          head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count_unused;
    logic                push;
    logic                pop;

    assign cm_ready  = !fifo_full && (state_q == ST_RUN);
    assign trc_valid = !fifo_empty && (state_q != ST_HALT);
    assign push      = cm_valid && cm_ready;
    assign pop       = trc_valid && trc_ready;

    // Pack the incoming commit into a FIFO record
    always_comb begin
        wdata        = '0;
        wdata.pc     = cm_pc;
        wdata.skip   = cm_skip;
        wdata.ebreak = cm_ebreak;
`ifdef TRACE_INST_EN
        wdata.inst   = cm_inst;
`endif
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset_n),
        .push_i  (push),
        .wdata_i (wdata),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    // Head fields are zeroed whenever nothing is offered so idle outputs read 0
    assign trc_pc   = trc_valid ? head.pc   : '0;
    assign trc_skip = trc_valid ? head.skip : 1'b0;
`ifdef TRACE_INST_EN
    assign trc_inst = trc_valid ? head.inst : '0;
`else
    logic unused_inst;
    assign unused_inst = ^cm_inst;
    assign trc_inst    = '0;
`endif

    // Phase FSM with halt capture: ebreak accepted -> drain, ebreak consumed -> halt
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            pend_code_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (push && cm_ebreak) begin
                        state_q     <= ST_DRAIN;
                        pend_code_q <= cm_a0;
                    end
                end
                ST_DRAIN: begin
                    if (pop && head.ebreak) begin
                        state_q     <= ST_HALT;
                        halt_q      <= 1'b1;
                        halt_code_q <= pend_code_q;
                    end
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    // Watchdog next-state: count idle cycles, saturate at WDOG_CYC-1, freeze in halt
    always_comb begin
        wdog_cnt_d  = wdog_cnt_q;
        wdog_trip_d = wdog_trip_q;
        if (state_q != ST_HALT) begin
            if (push) begin
                wdog_cnt_d = '0;
            end else if (wdog_cnt_q == WDOG_LAST) begin
                wdog_trip_d = 1'b1;
            end else begin
                wdog_cnt_d = wdog_cnt_q + WW'(1);
            end
        end
    end

    // Watchdog registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wdog_cnt_q  <= '0;
            wdog_trip_q <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    assign halt      = halt_q;
    assign halt_code = halt_code_q;
    assign wdog_trip = wdog_trip_q;

endmodule

// File: tb/tb_trace_commit_sched.sv
// Self-checking bench for trace_commit_sched (DEPTH=4, WDOG_CYC=16).
module tb_trace_commit_sched;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WDOG  = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cm_valid;
    logic        cm_ready;
    logic [63:0] cm_pc;
    logic        cm_skip;
    logic        cm_ebreak;
    logic [63:0] cm_a0;
    logic [31:0] cm_inst;
    logic        trc_valid;
    logic        trc_ready;
    logic [63:0] trc_pc;
    logic        trc_skip;
    logic [31:0] trc_inst;
    logic        halt;
    logic [63:0] halt_code;
    logic        wdog_trip;

    trace_commit_sched #(
        .DEPTH    (DEPTH),
        .WDOG_CYC (WDOG)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cm_valid  (cm_valid),
        .cm_ready  (cm_ready),
        .cm_pc     (cm_pc),
        .cm_skip   (cm_skip),
        .cm_ebreak (cm_ebreak),
        .cm_a0     (cm_a0),
        .cm_inst   (cm_inst),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_pc    (trc_pc),
        .trc_skip  (trc_skip),
        .trc_inst  (trc_inst),
        .halt      (halt),
        .halt_code (halt_code),
        .wdog_trip (wdog_trip)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic        skip;
        logic        eb;
        logic [31:0] inst;
    } mrec_t;

    mrec_t       mq[$];
    bit          m_accepting;   // still taking commits (no ebreak seen)
    bit          m_halted;
    logic [63:0] m_pend;
    logic [63:0] m_code;
    int          m_idle;
    bit          m_trip;

    function automatic bit m_ready();
        return (mq.size() < DEPTH) && m_accepting && !m_halted;
    endfunction

    function automatic bit m_tvalid();
        return (mq.size() != 0) && !m_halted;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_accepting = 1'b1;
        m_halted    = 1'b0;
        m_pend      = '0;
        m_code      = '0;
        m_idle      = 0;
        m_trip      = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic m_step(input logic v, input logic [63:0] pc, input logic skip,
                          input logic eb, input logic [63:0] a0, input logic [31:0] inst,
                          input logic rdy);
        bit    acc;
        bit    pp;
        mrec_t r;
        acc = v && m_ready();
        pp  = rdy && m_tvalid();
        if (m_halted) return;
        if (pp) begin
            r = mq.pop_front();
            if (r.eb) begin
                m_halted = 1'b1;
                m_code   = m_pend;
            end
        end
        if (acc) begin
            r.pc = pc; r.skip = skip; r.eb = eb; r.inst = inst;
            mq.push_back(r);
            if (eb) begin
                m_accepting = 1'b0;
                m_pend      = a0;
            end
            m_idle = 0;
        end else begin
            if (m_idle < WDOG) m_idle++;
            if (m_idle >= WDOG) m_trip = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic [63:0] epc;
        logic        eskip;
        logic [31:0] einst;
        epc = '0; eskip = 1'b0; einst = '0;
        if (m_tvalid()) begin
            epc   = mq[0].pc;
            eskip = mq[0].skip;
`ifdef TRACE_INST_EN
            einst = mq[0].inst;
`endif
        end
        chk("cm_ready",  {63'd0, cm_ready},  {63'd0, m_ready()});
        chk("trc_valid", {63'd0, trc_valid}, {63'd0, m_tvalid()});
        chk("trc_pc",    trc_pc, epc);
        chk("trc_skip",  {63'd0, trc_skip},  {63'd0, eskip});
        chk("trc_inst",  {32'd0, trc_inst},  {32'd0, einst});
        chk("halt",      {63'd0, halt},      {63'd0, m_halted});
        chk("halt_code", halt_code, m_code);
        chk("wdog_trip", {63'd0, wdog_trip}, {63'd0, m_trip});
    endtask

    // Drive one cycle of inputs, clock it, update model, then compare #1 after the edge
    task automatic cyc(input logic v, input logic [63:0] pc, input logic skip, input logic eb,
                       input logic [63:0] a0, input logic [31:0] inst, input logic rdy);
        cm_valid = v; cm_pc = pc; cm_skip = skip; cm_ebreak = eb;
        cm_a0 = a0; cm_inst = inst; trc_ready = rdy;
        @(posedge clock);
        if (!reset_n) m_reset();
        else m_step(v, pc, skip, eb, a0, inst, rdy);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(1'b1, 64'h1234, 1'b0, 1'b0, 64'h0, 32'h0, 1'b1);
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, rdy);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic        eb;
        logic [63:0] a0;
        logic        rdy;
        logic        e_ready;
        logic        e_tvalid;
        logic [63:0] e_pc;
        logic        e_halt;
    } vec_t;

    vec_t tbl[10];

    initial begin
        cm_valid = 0; cm_pc = '0; cm_skip = 0; cm_ebreak = 0; cm_a0 = '0;
        cm_inst = '0; trc_ready = 0;
        m_reset();

        // single record latency, then A,B,ebreak(a0=0) with stalled sink, then drain to halt
        tbl[0] = '{1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0};
        tbl[1] = '{1'b0, 64'h0,         1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0,         1'b0};
        tbl[2] = '{1'b1, 64'hA000,      1'b0, 64'h5, 1'b0, 1'b1, 1'b1, 64'hA000,      1'b0};
        tbl[3] = '{1'b1, 64'hB000,      1'b0, 64'h6, 1'b0, 1'b1, 1'b1, 64'hA000,      1'b0};
        tbl[4] = '{1'b1, 64'hC000,      1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 64'hA000,      1'b0};
        tbl[5] = '{1'b1, 64'hD000,      1'b0, 64'h7, 1'b0, 1'b0, 1'b1, 64'hA000,      1'b0};
        tbl[6] = '{1'b1, 64'hD000,      1'b0, 64'h7, 1'b1, 1'b0, 1'b1, 64'hB000,      1'b0};
        tbl[7] = '{1'b1, 64'hD000,      1'b0, 64'h7, 1'b1, 1'b0, 1'b1, 64'hC000,      1'b0};
        tbl[8] = '{1'b1, 64'hD000,      1'b0, 64'h7, 1'b1, 1'b0, 1'b0, 64'h0,         1'b1};
        tbl[9] = '{1'b1, 64'hE000,      1'b1, 64'h9, 1'b1, 1'b0, 1'b0, 64'h0,         1'b1};

        reset_n = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        reset_n = 1'b1;
        chk("rst_cm_ready", {63'd0, cm_ready}, 64'd1);
        chk("rst_trc_valid", {63'd0, trc_valid}, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        chk("rst_wdog", {63'd0, wdog_trip}, 64'd0);

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].pc, 1'b0, tbl[i].eb, tbl[i].a0, 32'h0, tbl[i].rdy);
            chk($sformatf("tbl%0d_cm_ready", i), {63'd0, cm_ready}, {63'd0, tbl[i].e_ready});
            chk($sformatf("tbl%0d_trc_valid", i), {63'd0, trc_valid}, {63'd0, tbl[i].e_tvalid});
            chk($sformatf("tbl%0d_trc_pc", i), trc_pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_halt", i), {63'd0, halt}, {63'd0, tbl[i].e_halt});
        end
        chk("halt_code_zero", halt_code, 64'h0);

        // fill to full with stalled sink, check stall stability and in-order drain
        do_reset();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 64'h100 + 64'(i), i[0], 1'b0, '0, 32'h1000 + i, 1'b0);
        chk("full_cm_ready", {63'd0, cm_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 64'hDEAD, 1'b0, 1'b0, '0, '0, 1'b0);
            chk("stall_pc", trc_pc, 64'h100);
        end
        // pop at full with a waiting commit: no bypass, so the commit is not accepted
        cyc(1'b1, 64'hBEEF, 1'b0, 1'b0, '0, '0, 1'b1);
        chk("nobypass_pc", trc_pc, 64'h101);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b1);
        chk("drained_empty", {63'd0, trc_valid}, 64'd0);

        // steady push+pop at occupancy 2 across pointer wrap
        do_reset();
        cyc(1'b1, 64'h200, 1'b0, 1'b0, '0, '0, 1'b0);
        cyc(1'b1, 64'h201, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 64'h202 + 64'(i), 1'b0, 1'b0, '0, '0, 1'b1);
            chk("steady_pc", trc_pc, 64'h201 + 64'(i));
        end

        // watchdog: restart on commit at idle cycle 10, then trip after the full idle run
        do_reset();
        idle(10, 1'b1);
        cyc(1'b1, 64'h300, 1'b0, 1'b0, '0, '0, 1'b1);
        idle(15, 1'b1);
        chk("wdog_not_yet", {63'd0, wdog_trip}, 64'd0);
        idle(2, 1'b1);
        chk("wdog_tripped", {63'd0, wdog_trip}, 64'd1);
        cyc(1'b1, 64'h301, 1'b0, 1'b0, '0, '0, 1'b1);
        chk("wdog_sticky", {63'd0, wdog_trip}, 64'd1);

        // reset while draining with three entries held
        do_reset();
        cyc(1'b1, 64'h400, 1'b0, 1'b0, '0, '0, 1'b0);
        cyc(1'b1, 64'h401, 1'b0, 1'b0, '0, '0, 1'b0);
        cyc(1'b1, 64'h402, 1'b0, 1'b1, 64'h55, '0, 1'b0);
        chk("drain_cm_ready", {63'd0, cm_ready}, 64'd0);
        do_reset();
        chk("rst6_trc_valid", {63'd0, trc_valid}, 64'd0);
        chk("rst6_cm_ready", {63'd0, cm_ready}, 64'd1);
        chk("rst6_halt", {63'd0, halt}, 64'd0);
        chk("rst6_code", halt_code, 64'd0);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        v, eb, rdy, sk;
            logic [63:0] pc, a0;
            v   = ($urandom_range(0, 9) < 6);
            eb  = ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 1) == 1);
            sk  = $urandom_range(0, 1) == 1;
            pc  = {$urandom, $urandom};
            a0  = {$urandom, $urandom};
            if ((halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
                reset_n = 1'b0;
            cyc(v, pc, sk, eb, a0, $urandom, rdy);
            reset_n = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
